controller_poller: RTL and testbench

//  Parametrised serial game-controller reader: drives a shared latch/clock pair to
//  NUM_CONTROLLERS NES-style shift-register pads and captures BUTTONS bits from each.

---
 rtl/controller_poller.sv | 155 +++++++++++++++
 tb/tb_controller_poller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/controller_poller.sv
`default_nettype none
// ============================================================================
// controller_poller: reads N NES-style shift-register pads over a shared
// latch/serial-clock pair at a programmable rate, with sticky press flags.
// Rev 1.0
// ============================================================================
module controller_poller #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int BUTTONS         = 8,
  parameter int CLK_DIV         = 1
) (
  input  logic                                 clk_1,
  input  logic                                 rst_B,
  input  logic                                 poll_start,
  output logic                                 busy,
  output logic                                 controller_latch,
  output logic                                 controller_clk_out,
  input  logic [NUM_CONTROLLERS-1:0]           controller_data_in_B,
  output logic [NUM_CONTROLLERS*BUTTONS-1:0]   buttons_out,
  output logic [NUM_CONTROLLERS*BUTTONS-1:0]   pressed_out,
  input  logic [NUM_CONTROLLERS*BUTTONS-1:0]   pressed_clear,
  output logic                                 buttons_valid
);

  localparam int NB = NUM_CONTROLLERS * BUTTONS;
  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam int KW = $clog2(BUTTONS);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [KW-1:0] K_LAST     = KW'(BUTTONS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [KW-1:0] bit_idx, bit_idx_nxt;
  logic          sample;
  logic          commit;
  logic [NB-1:0] shift_q;
  logic [NB-1:0] new_buttons;
  logic [NB-1:0] edges;
  logic [NB-1:0] edges_q;

  // Shifting left each sample puts the first bit read (bit B-1-0) in the MSB.
  for (genvar i = 0; i < NUM_CONTROLLERS; i++) begin : g_pad
    assign new_buttons[i*BUTTONS +: BUTTONS] =
      {shift_q[i*BUTTONS +: BUTTONS-1], ~controller_data_in_B[i]};
  end

  assign edges = new_buttons & ~buttons_out;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    sample      = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        if (poll_start) begin
          state_nxt = LATCH;
          cnt_nxt   = '0;
        end
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          state_nxt   = SHIFT_LO;
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SHIFT_LO: begin
        if (cnt == HALF_LAST) begin
          sample  = 1'b1;
          cnt_nxt = '0;
          if (bit_idx == K_LAST) begin
            commit    = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = SHIFT_HI;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt == HALF_LAST) begin
          state_nxt   = SHIFT_LO;
          cnt_nxt     = '0;
          bit_idx_nxt = bit_idx + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are glitch-free.
  always_ff @(posedge clk_1 or negedge rst_B) begin
    if (!rst_B) begin
      state              <= IDLE;
      cnt                <= '0;
      bit_idx            <= '0;
      busy               <= 1'b0;
      controller_latch   <= 1'b0;
      controller_clk_out <= 1'b0;
      buttons_valid      <= 1'b0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      bit_idx            <= bit_idx_nxt;
      busy               <= (state_nxt != IDLE);
      controller_latch   <= (state_nxt == LATCH);
      controller_clk_out <= (state_nxt == SHIFT_HI);
      buttons_valid      <= commit;
    end
  end

  // Results commit as DONE is entered so buttons_valid and buttons_out line up;
  // the edges are held through DONE so a clear in that cycle cannot beat a set.
  always_ff @(posedge clk_1 or negedge rst_B) begin
    if (!rst_B) begin
      shift_q     <= '0;
      buttons_out <= '0;
      pressed_out <= '0;
      edges_q     <= '0;
    end else begin
      if (sample) begin
        shift_q <= new_buttons;
      end
      if (commit) begin
        buttons_out <= new_buttons;
        pressed_out <= (pressed_out & ~pressed_clear) | edges;
        edges_q     <= edges;
      end else if (state == DONE) begin
        pressed_out <= (pressed_out & ~pressed_clear) | edges_q;
        edges_q     <= '0;
      end else begin
        pressed_out <= pressed_out & ~pressed_clear;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controller_poller.sv
`default_nettype none
// tb_controller_poller: directed vectors against three parameterisations of
// controller_poller with behavioural NES pad models.
module tb_controller_poller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // A: N=2 B=8 D=1
  logic        rst_a = 1'b0, start_a = 1'b0;
  logic [1:0]  din_a;
  logic        busy_a, latch_a, ck_a, val_a;
  logic [15:0] btn_a, prs_a;
  logic [15:0] clr_a = '0;
  logic [7:0]  load_a [2];
  logic [7:0]  sr_a   [2] = '{8'h00, 8'h00};

  // B: N=2 B=8 D=3
  logic        rst_b = 1'b0, start_b = 1'b0;
  logic [1:0]  din_b;
  logic        busy_b, latch_b, ck_b, val_b;
  logic [15:0] btn_b, prs_b;
  logic [15:0] clr_b = '0;
  logic [7:0]  load_b [2];
  logic [7:0]  sr_b   [2] = '{8'h00, 8'h00};

  // C: N=4 B=12 D=2
  logic        rst_c = 1'b0, start_c = 1'b0;
  logic [3:0]  din_c;
  logic        busy_c, latch_c, ck_c, val_c;
  logic [47:0] btn_c, prs_c;
  logic [47:0] clr_c = '0;
  logic [11:0] load_c [4];
  logic [11:0] sr_c   [4] = '{12'h000, 12'h000, 12'h000, 12'h000};

  // Pad model: parallel load on latch, first bit out is the MSB, shift on clk rise.
  always @(posedge latch_a or posedge ck_a)
    for (int i = 0; i < 2; i++) sr_a[i] <= latch_a ? load_a[i] : (sr_a[i] << 1);
  always @(posedge latch_b or posedge ck_b)
    for (int i = 0; i < 2; i++) sr_b[i] <= latch_b ? load_b[i] : (sr_b[i] << 1);
  always @(posedge latch_c or posedge ck_c)
    for (int i = 0; i < 4; i++) sr_c[i] <= latch_c ? load_c[i] : (sr_c[i] << 1);

  assign din_a = {~sr_a[1][7], ~sr_a[0][7]};
  assign din_b = {~sr_b[1][7], ~sr_b[0][7]};
  assign din_c = {~sr_c[3][11], ~sr_c[2][11], ~sr_c[1][11], ~sr_c[0][11]};

  controller_poller #(.NUM_CONTROLLERS(2), .BUTTONS(8), .CLK_DIV(1)) dut_a (
    .clk_1(clk), .rst_B(rst_a), .poll_start(start_a), .busy(busy_a),
    .controller_latch(latch_a), .controller_clk_out(ck_a),
    .controller_data_in_B(din_a), .buttons_out(btn_a), .pressed_out(prs_a),
    .pressed_clear(clr_a), .buttons_valid(val_a));

  controller_poller #(.NUM_CONTROLLERS(2), .BUTTONS(8), .CLK_DIV(3)) dut_b (
    .clk_1(clk), .rst_B(rst_b), .poll_start(start_b), .busy(busy_b),
    .controller_latch(latch_b), .controller_clk_out(ck_b),
    .controller_data_in_B(din_b), .buttons_out(btn_b), .pressed_out(prs_b),
    .pressed_clear(clr_b), .buttons_valid(val_b));

  controller_poller #(.NUM_CONTROLLERS(4), .BUTTONS(12), .CLK_DIV(2)) dut_c (
    .clk_1(clk), .rst_B(rst_c), .poll_start(start_c), .busy(busy_c),
    .controller_latch(latch_c), .controller_clk_out(ck_c),
    .controller_data_in_B(din_c), .buttons_out(btn_c), .pressed_out(prs_c),
    .pressed_clear(clr_c), .buttons_valid(val_c));

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] mon(input int sel);
    case (sel)
      0:       mon = {busy_a, latch_a, ck_a, val_a};
      1:       mon = {busy_b, latch_b, ck_b, val_b};
      default: mon = {busy_c, latch_c, ck_c, val_c};
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Observations of the last poll, cycle 1 = first cycle after the accepting edge.
  int   vcyc, lat, pul, nval, ovl, ckhi;
  logic busy1, busy_after;

  task automatic poll(input int sel, input int win, input int xs,
                      input logic [15:0] clr, input int clr_cyc);
    logic [3:0] m;
    logic       pck;
    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); set_start(sel, 1'b0);
    vcyc = 0; lat = 0; pul = 0; nval = 0; ovl = 0; ckhi = 0;
    busy1 = 1'b0; busy_after = 1'b1; pck = 1'b0;
    for (int c = 1; c <= win; c++) begin
      m = mon(sel);
      if (c == 1) busy1 = m[3];
      if (vcyc != 0 && c == vcyc + 1) busy_after = m[3];
      if (m[2]) lat++;
      if (m[1]) ckhi++;
      if (m[1] && !pck) pul++;
      pck = m[1];
      if (m[2] && m[1]) ovl++;
      if (m[0]) begin
        nval++;
        if (vcyc == 0) vcyc = c;
      end
      set_start(sel, c == xs);
      if (sel == 0) clr_a = (c == clr_cyc || c == clr_cyc + 1) ? clr : 16'h0000;
      @(negedge clk);
    end
    set_start(sel, 1'b0);
    clr_a = '0;
  endtask

  initial begin
    int quiet;
    repeat (3) @(negedge clk);
    check_vec("reset_a", {busy_a, latch_a, ck_a, val_a, btn_a, prs_a}, '0);
    check_vec("reset_b", {busy_b, latch_b, ck_b, val_b, btn_b, prs_b}, '0);
    check_vec("reset_c", {busy_c, latch_c, ck_c, val_c, btn_c, prs_c}, '0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      if (latch_a | ck_a | val_a | busy_a | latch_b | ck_b | val_b | busy_b |
          latch_c | ck_c | val_c | busy_c) quiet++;
    end
    check_vec("idle_quiet", quiet, 0);

    // Basic poll, D=1
    load_a[0] = 8'h7F; load_a[1] = 8'hFE;
    poll(0, 30, 0, 16'h0, 0);
    check_vec("basic_btn", btn_a, 16'hFE7F);
    check_vec("basic_prs", prs_a, 16'hFE7F);
    check_vec("basic_vcyc", vcyc, 18);
    check_vec("basic_latch", lat, 2);
    check_vec("basic_pulses", pul, 7);
    check_vec("basic_nval", nval, 1);
    check_vec("basic_overlap", ovl, 0);
    check_vec("basic_busy1", busy1, 1);
    check_vec("basic_busy_after", busy_after, 0);

    // Rate, D=3
    load_b[0] = 8'h7F; load_b[1] = 8'hFE;
    poll(1, 70, 0, 16'h0, 0);
    check_vec("rate_btn", btn_b, 16'hFE7F);
    check_vec("rate_vcyc", vcyc, 52);
    check_vec("rate_latch", lat, 6);
    check_vec("rate_pulses", pul, 7);
    check_vec("rate_ckhigh", ckhi, 21);
    check_vec("rate_nval", nval, 1);
    check_vec("rate_overlap", ovl, 0);

    // Edges and clear
    @(negedge clk) clr_a = 16'hFFFF;
    @(negedge clk) clr_a = 16'h0000;
    check_vec("clear_all", prs_a, 16'h0000);
    load_a[0] = 8'h00; load_a[1] = 8'h00;
    poll(0, 30, 0, 16'h0, 0);
    check_vec("edge_p0_btn", btn_a, 16'h0000);
    check_vec("edge_p0_prs", prs_a, 16'h0000);
    load_a[0] = 8'h05;
    poll(0, 30, 0, 16'h0, 0);
    check_vec("edge_p5_btn", btn_a, 16'h0005);
    check_vec("edge_p5_prs", prs_a, 16'h0005);
    poll(0, 30, 0, 16'h0001, 17);
    check_vec("edge_clr_bit0", prs_a, 16'h0004);
    load_a[0] = 8'h07;
    poll(0, 30, 0, 16'h0002, 17);
    check_vec("edge_set_wins", prs_a, 16'h0006);
    check_vec("edge_p7_btn", btn_a, 16'h0007);

    // poll_start during SHIFT is ignored
    load_a[0] = 8'hA5; load_a[1] = 8'h3C;
    poll(0, 30, 8, 16'h0, 0);
    check_vec("busy_nval", nval, 1);
    check_vec("busy_vcyc", vcyc, 18);
    check_vec("busy_btn", btn_a, 16'h3CA5);
    check_vec("busy_prs", prs_a, 16'h3CA6);

    // Reset mid-poll at k=4 (cycle 11)
    load_a[0] = 8'h81; load_a[1] = 8'h42;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (10) @(negedge clk);
    check_vec("mid_busy", busy_a, 1);
    rst_a = 1'b0;
    #1;
    check_vec("mid_reset", {busy_a, latch_a, ck_a, val_a, btn_a, prs_a}, '0);
    @(negedge clk) rst_a = 1'b1;
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (val_a) quiet++;
    end
    check_vec("mid_no_valid", quiet, 0);
    poll(0, 30, 0, 16'h0, 0);
    check_vec("post_btn", btn_a, 16'h4281);
    check_vec("post_prs", prs_a, 16'h4281);
    check_vec("post_vcyc", vcyc, 18);

    // Scale, N=4 B=12 D=2
    load_c[0] = 12'hA5C; load_c[1] = 12'h3F0; load_c[2] = 12'h001; load_c[3] = 12'hFFF;
    poll(2, 70, 0, 16'h0, 0);
    check_vec("scale_btn", btn_c, 48'hFFF0013F0A5C);
    check_vec("scale_prs", prs_c, 48'hFFF0013F0A5C);
    check_vec("scale_vcyc", vcyc, 51);
    check_vec("scale_latch", lat, 4);
    check_vec("scale_pulses", pul, 11);
    check_vec("scale_nval", nval, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
